// File: rtl/reg_rr_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter.
//   state_t : two-state write FSM encoding (IDLE / WRITE)
//   clog2   : index width helper, never narrower than 1 bit
package reg_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/reg_rr_arbiter_pick.sv
// Combinational round-robin selector.
//   cand   : M-bit candidate vector
//   ptr    : index of the previous winner; search starts at (ptr+1) mod M
//   winner : index of the first set candidate bit at or after the start
//   found  : high when any candidate bit is set
// The vector is rotated so the start index sits at bit 0, the lowest set bit
// is priority-encoded, and the result is rotated back by adding the start.
module rr_pick #(
    parameter int M  = 4,
    parameter int IW = 2
) (
    input  logic [M-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    // Doubling the vector turns every rotation into a plain part-select.
    // The top copy of cand[M-1] is never selected, so it is left out.
    logic [2*M-2:0] cand_dbl;
    logic [M-1:0]   rot_opt [M];
    logic [M-1:0]   rot;
    logic [IW-1:0]  start;
    logic [IW-1:0]  idx;
    logic [IW:0]    sum;

    assign cand_dbl = {cand[M-2:0], cand};

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_rot
            assign rot_opt[gi] = cand_dbl[gi +: M];
        end
    endgenerate

    // M need not be a power of two, so the wrap is explicit.
    assign start = (ptr == IW'(M - 1)) ? '0 : ptr + 1'b1;
    assign rot   = rot_opt[start];

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        sum = {1'b0, idx} + {1'b0, start};
        if (sum >= (IW + 1)'(M)) begin
            sum = sum - (IW + 1)'(M);
        end
        winner = sum[IW-1:0];
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit enable register between M requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level requests, one bit per requester
//   wdata      : requester i write data at [i*N +: N]
//   gnt        : registered one-hot grant, one cycle per committed write
//   reg_x      : data to the shared register (valid when reg_en is high)
//   reg_en     : shared register enable, high during the WRITE cycle
//   owner      : requester whose write last completed
//   owner_vld  : at least one write has completed since reset
//   busy       : FSM is in WRITE (same as reg_en)
// All outputs come straight from registers; req only steers next state.
module reg_rr_arbiter
    import reg_rr_arbiter_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int M  = 4,
    localparam int IW = clog2(M)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [M-1:0]    req,
    input  logic [M*N-1:0]  wdata,
    output logic [M-1:0]    gnt,
    output logic [N-1:0]    reg_x,
    output logic            reg_en,
    output logic [IW-1:0]   owner,
    output logic            owner_vld,
    output logic            busy
);

    state_t          state_reg,  state_next;
    logic [IW-1:0]   win_reg,    win_next;
    logic [M-1:0]    gnt_reg,    gnt_next;
    logic [N-1:0]    data_q_reg, data_q_next;
    logic [IW-1:0]   ptr_reg,    ptr_next;
    logic [IW-1:0]   owner_reg,  owner_next;
    logic            owner_vld_reg, owner_vld_next;

    logic [M-1:0]    cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic [M-1:0]    pick_onehot;
    logic [N-1:0]    wdata_arr [M];

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_unpack
            assign wdata_arr[gi]   = wdata[gi*N +: N];
            assign pick_onehot[gi] = (pick_idx == IW'(gi));
        end
    endgenerate

    // The requester being served this cycle is excluded, so a held request
    // is treated as new only in the cycle after its grant.
    assign cand = (state_reg == ST_WRITE) ? (req & ~gnt_reg) : req;

    rr_pick #(
        .M  (M),
        .IW (IW)
    ) u_pick (
        .cand   (cand),
        .ptr    (ptr_reg),
        .winner (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_next     = state_reg;
        win_next       = win_reg;
        gnt_next       = gnt_reg;
        data_q_next    = data_q_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        owner_vld_next = owner_vld_reg;

        // The write in flight completes at this edge.
        if (state_reg == ST_WRITE) begin
            owner_next     = win_reg;
            owner_vld_next = 1'b1;
            state_next     = ST_IDLE;
            gnt_next       = '0;
        end

        // A new grant from either state; WRITE->WRITE gives 1 write/cycle.
        if (pick_found) begin
            state_next  = ST_WRITE;
            win_next    = pick_idx;
            gnt_next    = pick_onehot;
            data_q_next = wdata_arr[pick_idx];
            ptr_next    = pick_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            win_reg       <= '0;
            gnt_reg       <= '0;
            data_q_reg    <= '0;
            ptr_reg       <= IW'(M - 1);
            owner_reg     <= '0;
            owner_vld_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            win_reg       <= win_next;
            gnt_reg       <= gnt_next;
            data_q_reg    <= data_q_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            owner_vld_reg <= owner_vld_next;
        end
    end

    assign gnt       = gnt_reg;
    assign reg_x     = data_q_reg;
    assign reg_en    = (state_reg == ST_WRITE);
    assign busy      = (state_reg == ST_WRITE);
    assign owner     = owner_reg;
    assign owner_vld = owner_vld_reg;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Scoreboard bench for reg_rr_arbiter (N=8, M=4) with a model of the
// shared register attached to reg_x/reg_en.
module tb_reg_rr_arbiter;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [N-1:0]  data;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [M-1:0]    req;
    logic [M*N-1:0]  wdata;
    logic [M-1:0]    gnt;
    logic [N-1:0]    reg_x;
    logic            reg_en;
    logic [IW-1:0]   owner;
    logic            owner_vld;
    logic            busy;

    exp_t            exp_q [$];
    int              tests;
    int              fails;
    logic [N-1:0]    shreg;
    logic            pend_en;
    logic [N-1:0]    pend_x;

    reg_rr_arbiter #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .reg_x     (reg_x),
        .reg_en    (reg_en),
        .owner     (owner),
        .owner_vld (owner_vld),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [N-1:0] data);
        exp_t e;
        e.idx  = IW'(idx);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Shared register model: sample enable/data mid-cycle, commit at the
    // next rising edge unless reset cut the write short.
    always @(negedge clk) begin
        pend_en = reg_en;
        pend_x  = reg_x;
    end
    always @(negedge rst_n) pend_en = 1'b0;
    always @(posedge clk) begin
        if (pend_en && rst_n) shreg = pend_x;
    end

    // Monitor: every write cycle is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        chk("busy_eq_en", {31'b0, busy}, {31'b0, reg_en});
        if (reg_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {28'b0, gnt}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] write: gnt=%b reg_x=%02h (exp req %0d data %02h)", gnt, reg_x, e.idx, e.data);
                chk("sb_gnt", {28'b0, gnt}, 32'h1 << e.idx);
                chk("sb_reg_x", {24'b0, reg_x}, {24'b0, e.data});
            end
        end else begin
            chk("idle_gnt", {28'b0, gnt}, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tests   = 0;
        fails   = 0;
        shreg   = 8'h00;
        pend_en = 1'b0;
        pend_x  = '0;
        rst_n   = 1'b0;
        req     = 4'b1111;
        wdata   = 32'h13121110;

        // Reset state with all requests asserted.
        repeat (2) tick();
        chk("rst_gnt", {28'b0, gnt}, 32'h0);
        chk("rst_reg_en", {31'b0, reg_en}, 32'h0);
        chk("rst_reg_x", {24'b0, reg_x}, 32'h0);
        chk("rst_owner", {30'b0, owner}, 32'h0);
        chk("rst_owner_vld", {31'b0, owner_vld}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);

        // Full contention: 0,1,2,3,0 back to back, starting at requester 0.
        push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
        rst_n = 1'b1;
        tick();
        chk("cont_first_gnt", {28'b0, gnt}, 32'h1);
        repeat (4) begin
            tick();
            chk("cont_no_idle", {31'b0, reg_en}, 32'h1);
        end
        req = 4'b0000;
        tick();
        chk("cont_reg", {24'b0, shreg}, 32'h10);
        chk("cont_owner", {30'b0, owner}, 32'h0);
        chk("cont_owner_vld", {31'b0, owner_vld}, 32'h1);
        chk("cont_idle", {31'b0, reg_en}, 32'h0);

        // Single request from requester 2.
        wdata[2*N +: N] = 8'hA5;
        req = 4'b0100;
        push(2, 8'hA5);
        tick();
        chk("single_gnt", {28'b0, gnt}, 32'h4);
        chk("single_reg_x", {24'b0, reg_x}, 32'hA5);
        req = 4'b0000;
        tick();
        chk("single_reg", {24'b0, shreg}, 32'hA5);
        chk("single_owner", {30'b0, owner}, 32'h2);
        chk("single_busy", {31'b0, busy}, 32'h0);

        // Lone held request: granted every other cycle.
        wdata[1*N +: N] = 8'h77;
        req = 4'b0010;
        push(1, 8'h77); push(1, 8'h77); push(1, 8'h77);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lone_gnt", {28'b0, gnt}, (i % 2 == 0) ? 32'h2 : 32'h0);
            chk("lone_en", {31'b0, reg_en}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        req = 4'b0000;
        tick();

        // Data capture: wdata change during WRITE must not leak through.
        wdata[3*N +: N] = 8'h3C;
        req = 4'b1000;
        push(3, 8'h3C);
        tick();
        wdata[3*N +: N] = 8'hFF;
        req = 4'b0000;
        #2;
        chk("cap_reg_x", {24'b0, reg_x}, 32'h3C);
        tick();
        chk("cap_reg", {24'b0, shreg}, 32'h3C);

        // Put 8'h55 in the register, then abort a write by reset.
        wdata[0*N +: N] = 8'h55;
        req = 4'b0001;
        push(0, 8'h55);
        tick();
        req = 4'b0000;
        tick();
        chk("pre_abort_reg", {24'b0, shreg}, 32'h55);
        wdata[3*N +: N] = 8'hAA;
        req = 4'b1000;
        tick();
        chk("abort_gnt_before", {28'b0, gnt}, 32'h8);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt", {28'b0, gnt}, 32'h0);
        chk("abort_en", {31'b0, reg_en}, 32'h0);
        chk("abort_owner_vld", {31'b0, owner_vld}, 32'h0);
        wdata[0*N +: N] = 8'h61;
        wdata[3*N +: N] = 8'h63;
        req = 4'b1001;
        tick();
        chk("abort_reg", {24'b0, shreg}, 32'h55);
        push(0, 8'h61); push(3, 8'h63);
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt", {28'b0, gnt}, 32'h1);
        tick();
        chk("post_rst_gnt2", {28'b0, gnt}, 32'h8);
        req = 4'b0000;
        repeat (2) tick();
        chk("post_rst_reg", {24'b0, shreg}, 32'h63);
        chk("post_rst_owner", {30'b0, owner}, 32'h3);

        chk("sb_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
